// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared helpers for the parameterised reservation station
package rs_pkg;

    // Helpers operate on fixed maximum widths; callers zero-extend and
    // truncate back to their own widths with size casts.
    localparam int RS_VEC_W = 32;
    localparam int RS_TAG_W = 16;

    // Isolates the lowest set bit (the lowest-index free slot).
    function automatic logic [RS_VEC_W-1:0] onehot_lowest(input logic [RS_VEC_W-1:0] vec);
        return vec & (~vec + RS_VEC_W'(1));
    endfunction

    function automatic logic tag_match(input logic [RS_TAG_W-1:0] a,
                                       input logic [RS_TAG_W-1:0] b);
        return a == b;
    endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// rtl/rs_age_matrix.sv - allocation-order age matrix with oldest-eligible grant
//
// age_q[r][c] = 1 means entry r is older than entry c.
// Ports: clk, rst_i (sync, active-high), clr_i (flush), alloc_i/free_i (one-hot),
//        elig_i (eligible vector), grant_o (one-hot oldest eligible).
module rs_age_matrix #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic [DEPTH-1:0] alloc_i,
    input  logic [DEPTH-1:0] free_i,
    input  logic [DEPTH-1:0] elig_i,
    output logic [DEPTH-1:0] grant_o
);

    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];

    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            age_d[r] = age_q[r];
            // A new entry is older than nobody; a freed entry's row is stale.
            if (alloc_i[r] || free_i[r]) age_d[r] = '0;
        end
        // Every other entry is older than the one being written.
        for (int r = 0; r < DEPTH; r++) begin
            for (int c = 0; c < DEPTH; c++) begin
                if (alloc_i[c] && r != c) age_d[r][c] = 1'b1;
            end
        end
        // Grant an eligible entry that no other eligible entry is older than.
        for (int i = 0; i < DEPTH; i++) begin
            grant_o[i] = elig_i[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && elig_i[j] && age_q[j][i]) grant_o[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < DEPTH; r++) begin
            if (rst_i || clr_i) age_q[r] <= '0;
            else                age_q[r] <= age_d[r];
        end
    end

endmodule

// File: rtl/param_reservation_station.sv
// rtl/param_reservation_station.sv - N-entry reservation station with CDB wakeup and age-ordered issue
//
// Ports: clk/globalReset (sync, active-high); rename side writeReq, instrRob, control,
//        value1/2, ready1/2, rob1/2 with full, freeCount, busy; CDB snoop cdbValid,
//        cdbRob, cdbResult (packed per port); FU side fuReady, issueValid, issueRob,
//        issueCtrl, src1, src2; clear flushes all entries.
module param_reservation_station
    import rs_pkg::*;
#(
    parameter int WIDTH     = 31,
    parameter int ROB       = 2,
    parameter int CTRL      = 7,
    parameter int DEPTH     = 4,
    parameter int CDB_PORTS = 1
) (
    input  logic                           clk,
    input  logic                           globalReset,
    input  logic                           writeReq,
    input  logic [ROB:0]                   instrRob,
    input  logic [CTRL:0]                  control,
    input  logic [WIDTH:0]                 value1,
    input  logic [WIDTH:0]                 value2,
    input  logic                           ready1,
    input  logic                           ready2,
    input  logic [ROB:0]                   rob1,
    input  logic [ROB:0]                   rob2,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     freeCount,
    output logic [DEPTH-1:0]               busy,
    input  logic [CDB_PORTS-1:0]           cdbValid,
    input  logic [CDB_PORTS*(ROB+1)-1:0]   cdbRob,
    input  logic [CDB_PORTS*(WIDTH+1)-1:0] cdbResult,
    input  logic                           fuReady,
    output logic                           issueValid,
    output logic [ROB:0]                   issueRob,
    output logic [CTRL:0]                  issueCtrl,
    output logic [WIDTH:0]                 src1,
    output logic [WIDTH:0]                 src2,
    input  logic                           clear
);

    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic           valid;
        logic           rdy1;
        logic           rdy2;
        logic [ROB:0]   tag1;
        logic [ROB:0]   tag2;
        logic [WIDTH:0] val1;
        logic [WIDTH:0] val2;
        logic [ROB:0]   rob;
        logic [CTRL:0]  ctrl;
    } rs_entry_t;

    rs_entry_t        ent_q [DEPTH];
    rs_entry_t        ent_d [DEPTH];
    rs_entry_t        new_ent;
    logic [CW-1:0]    free_cnt_q, free_cnt_d;
    logic [DEPTH-1:0] valid_vec, elig, grant, alloc_oh, free_oh;
    logic             alloc_en, fire;
    logic [ROB:0]     cdb_tag [CDB_PORTS];
    logic [WIDTH:0]   cdb_val [CDB_PORTS];
    logic [WIDTH+1:0] s1, s2, nb1, nb2;

    for (genvar p = 0; p < CDB_PORTS; p++) begin : g_cdb
        assign cdb_tag[p] = cdbRob[p*(ROB+1) +: ROB+1];
        assign cdb_val[p] = cdbResult[p*(WIDTH+1) +: WIDTH+1];
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_vec
        assign valid_vec[i] = ent_q[i].valid;
        assign elig[i]      = ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2;
    end

    // Returns {hit, value}; scanning high to low lets the lowest port win.
    function automatic logic [WIDTH+1:0] snoop(input logic [ROB:0] tag);
        logic [WIDTH+1:0] r;
        r = '0;
        for (int p = CDB_PORTS-1; p >= 0; p--) begin
            if (cdbValid[p] && tag_match(RS_TAG_W'(tag), RS_TAG_W'(cdb_tag[p])))
                r = {1'b1, cdb_val[p]};
        end
        return r;
    endfunction

    assign busy       = valid_vec;
    assign full       = &valid_vec;
    assign freeCount  = free_cnt_q;
    assign issueValid = (|elig) && !clear;
    assign fire       = issueValid && fuReady;
    assign free_oh    = fire ? grant : '0;
    assign alloc_en   = writeReq && !full && !clear;
    assign alloc_oh   = alloc_en ? DEPTH'(onehot_lowest(RS_VEC_W'(~valid_vec))) : '0;

    rs_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk     (clk),
        .rst_i   (globalReset),
        .clr_i   (clear),
        .alloc_i (alloc_oh),
        .free_i  (free_oh),
        .elig_i  (elig),
        .grant_o (grant)
    );

    always_comb begin
        // Incoming op: operands broadcast in the write cycle are captured now.
        nb1 = snoop(rob1);
        nb2 = snoop(rob2);
        new_ent       = '0;
        new_ent.valid = 1'b1;
        new_ent.rdy1  = ready1 || nb1[WIDTH+1];
        new_ent.rdy2  = ready2 || nb2[WIDTH+1];
        new_ent.tag1  = rob1;
        new_ent.tag2  = rob2;
        new_ent.val1  = ready1 ? value1 : nb1[WIDTH:0];
        new_ent.val2  = ready2 ? value2 : nb2[WIDTH:0];
        new_ent.rob   = instrRob;
        new_ent.ctrl  = control;
        s1 = '0;
        s2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            s1 = snoop(ent_q[i].tag1);
            s2 = snoop(ent_q[i].tag2);
            if (!ent_q[i].rdy1 && s1[WIDTH+1]) begin
                ent_d[i].rdy1 = 1'b1;
                ent_d[i].val1 = s1[WIDTH:0];
            end
            if (!ent_q[i].rdy2 && s2[WIDTH+1]) begin
                ent_d[i].rdy2 = 1'b1;
                ent_d[i].val2 = s2[WIDTH:0];
            end
            if (free_oh[i])  ent_d[i].valid = 1'b0;
            if (alloc_oh[i]) ent_d[i] = new_ent;
            if (clear)       ent_d[i].valid = 1'b0;
        end
        free_cnt_d = clear ? CW'(DEPTH) : free_cnt_q - CW'(alloc_en) + CW'(fire);
    end

    always_comb begin
        issueRob  = '0;
        issueCtrl = '0;
        src1      = '0;
        src2      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (issueValid && grant[i]) begin
                issueRob  |= ent_q[i].rob;
                issueCtrl |= ent_q[i].ctrl;
                src1      |= ent_q[i].val1;
                src2      |= ent_q[i].val2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (globalReset) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            free_cnt_q <= CW'(DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            free_cnt_q <= free_cnt_d;
        end
    end

endmodule
